// File: rtl/bp_me_burst_arb.sv
// bp_me_burst_arb
// ---------------
// Merges num_src_p BP Burst sources onto one BP Burst output channel.
// Each source sends a header, followed by the number of data beats given in
// the header's beat-count field. Sources are served round-robin. A message
// is never interleaved with another: once a header is accepted, the granted
// source's data channel is wired straight to the output until its last beat
// has gone.
//
// Handshake rule: a transfer happens in a cycle where valid and ready are both
// high. Producers do not wait for ready before raising valid. Once valid is
// raised, the payload and valid are held until the transfer happens.
// Ready outputs depend only on downstream ready, FSM state and, in idle, on
// which source wins arbitration.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   in_header_i/_v_i          per-source headers (source i at slice i)
//   in_header_ready_and_o     per-source header ready
//   in_data_i/_v_i            per-source data beats
//   in_data_ready_and_o       per-source data ready
//   out_header_o/_v_o         merged header, valid
//   out_header_ready_and_i    downstream header ready
//   out_data_o/_v_o           merged data beat, valid
//   out_data_ready_and_i      downstream data ready
//   out_src_id_o              index of the source currently presented
module bp_me_burst_arb #(
    parameter int num_src_p      = 2,
    parameter int header_width_p = 128,
    parameter int data_width_p   = 64,
    parameter int beats_offset_p = 0,
    parameter int beats_width_p  = 4,
    localparam int src_id_width_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [num_src_p*header_width_p-1:0] in_header_i,
    input  logic [num_src_p-1:0]                in_header_v_i,
    output logic [num_src_p-1:0]                in_header_ready_and_o,
    input  logic [num_src_p*data_width_p-1:0]   in_data_i,
    input  logic [num_src_p-1:0]                in_data_v_i,
    output logic [num_src_p-1:0]                in_data_ready_and_o,
    output logic [header_width_p-1:0]           out_header_o,
    output logic                                out_header_v_o,
    input  logic                                out_header_ready_and_i,
    output logic [data_width_p-1:0]             out_data_o,
    output logic                                out_data_v_o,
    input  logic                                out_data_ready_and_i,
    output logic [src_id_width_lp-1:0]          out_src_id_o
);

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_hdr  = 2'd1,
        e_data = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [src_id_width_lp-1:0] rr_q, rr_d;
    logic [src_id_width_lp-1:0] grant_q, grant_d;
    logic [beats_width_p-1:0]   count_q, count_d;

    // Unpacked views of the flat source buses.
    logic [header_width_p-1:0] hdr_a  [num_src_p];
    logic [data_width_p-1:0]   data_a [num_src_p];

    for (genvar gi = 0; gi < num_src_p; gi++) begin : g_unpack
        assign hdr_a[gi]  = in_header_i[gi*header_width_p +: header_width_p];
        assign data_a[gi] = in_data_i[gi*data_width_p +: data_width_p];
    end

    // Round-robin search: first valid header starting at rr_q, wrapping.
    logic [src_id_width_lp-1:0] winner;
    logic                       any_v;
    int                         idx;

    always_comb begin
        winner = rr_q;
        any_v  = 1'b0;
        idx    = 0;
        for (int k = 0; k < num_src_p; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= num_src_p) begin
                idx = idx - num_src_p;
            end
            if (!any_v && in_header_v_i[idx]) begin
                any_v  = 1'b1;
                winner = src_id_width_lp'(idx);
            end
        end
    end

    // In idle the winner is presented live; afterwards only the latched grant.
    logic [src_id_width_lp-1:0] sel;
    logic [header_width_p-1:0]  hdr_sel;
    logic [beats_width_p-1:0]   hdr_beats;
    logic                       hdr_phase;
    logic                       hdr_v_raw;
    logic                       hdr_hs;
    logic                       data_hs;
    logic [src_id_width_lp-1:0] sel_next;

    always_comb begin
        sel       = (state_q == e_idle) ? winner : grant_q;
        hdr_sel   = hdr_a[sel];
        hdr_beats = hdr_sel[beats_offset_p +: beats_width_p];
        // In idle nothing is presented unless some source is valid, so no
        // source sees header ready in that case.
        hdr_phase = ((state_q == e_idle) && any_v) || (state_q == e_hdr);
        case (state_q)
            e_idle:  hdr_v_raw = any_v;
            e_hdr:   hdr_v_raw = in_header_v_i[grant_q];
            default: hdr_v_raw = 1'b0;
        endcase
        sel_next = (sel == src_id_width_lp'(num_src_p - 1)) ? '0 : sel + 1'b1;
    end

    assign out_header_o   = hdr_sel;
    assign out_header_v_o = hdr_v_raw & ~reset_i;
    assign out_data_o     = data_a[grant_q];
    assign out_data_v_o   = (state_q == e_data) & in_data_v_i[grant_q] & ~reset_i;
    assign out_src_id_o   = sel;

    assign hdr_hs  = out_header_v_o & out_header_ready_and_i;
    assign data_hs = out_data_v_o & out_data_ready_and_i;

    always_comb begin
        in_header_ready_and_o = '0;
        in_data_ready_and_o   = '0;
        for (int i = 0; i < num_src_p; i++) begin
            in_header_ready_and_o[i] = ~reset_i & hdr_phase
                                     & (sel == src_id_width_lp'(i))
                                     & out_header_ready_and_i;
            in_data_ready_and_o[i]   = ~reset_i & (state_q == e_data)
                                     & (grant_q == src_id_width_lp'(i))
                                     & out_data_ready_and_i;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        count_d = count_q;
        case (state_q)
            e_idle, e_hdr: begin
                if (hdr_hs) begin
                    rr_d = sel_next;
                    if (hdr_beats != '0) begin
                        grant_d = sel;
                        count_d = hdr_beats;
                        state_d = e_data;
                    end else begin
                        state_d = e_idle;
                    end
                end else if ((state_q == e_idle) && any_v) begin
                    // Stalled header: freeze the choice so the presented
                    // header cannot change before it is accepted.
                    grant_d = winner;
                    state_d = e_hdr;
                end
            end
            e_data: begin
                if (data_hs) begin
                    count_d = count_q - 1'b1;
                    if (count_q == beats_width_p'(1)) begin
                        state_d = e_idle;
                    end
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_idle;
            rr_q    <= '0;
            grant_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_bp_me_burst_arb.sv
// Bench for bp_me_burst_arb with two sources. The model tracks, per message,
// which source owns the output, how many beats remain, the round-robin
// pointer and a stalled-header lock; expected outputs are derived from that
// each cycle and compared on the falling edge.
module tb_bp_me_burst_arb;
    localparam int N  = 2;
    localparam int HW = 128;
    localparam int DW = 64;
    localparam int BW = 4;
    localparam int SW = 1;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    logic [N*HW-1:0] in_header_i;
    logic [N-1:0]    in_header_v_i;
    logic [N-1:0]    in_header_ready_and_o;
    logic [N*DW-1:0] in_data_i;
    logic [N-1:0]    in_data_v_i;
    logic [N-1:0]    in_data_ready_and_o;
    logic [HW-1:0]   out_header_o;
    logic            out_header_v_o;
    logic            out_header_ready_and_i;
    logic [DW-1:0]   out_data_o;
    logic            out_data_v_o;
    logic            out_data_ready_and_i;
    logic [SW-1:0]   out_src_id_o;

    bp_me_burst_arb #(
        .num_src_p(N), .header_width_p(HW), .data_width_p(DW),
        .beats_offset_p(0), .beats_width_p(BW)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .in_header_i(in_header_i), .in_header_v_i(in_header_v_i),
        .in_header_ready_and_o(in_header_ready_and_o),
        .in_data_i(in_data_i), .in_data_v_i(in_data_v_i),
        .in_data_ready_and_o(in_data_ready_and_o),
        .out_header_o(out_header_o), .out_header_v_o(out_header_v_o),
        .out_header_ready_and_i(out_header_ready_and_i),
        .out_data_o(out_data_o), .out_data_v_o(out_data_v_o),
        .out_data_ready_and_i(out_data_ready_and_i),
        .out_src_id_o(out_src_id_o)
    );

    // Source-side stimulus state.
    logic [HW-1:0] s_hdr [N];
    logic [DW-1:0] s_data[N];
    logic [N-1:0]  s_hv;
    logic [N-1:0]  s_dv;
    int            s_left[N];
    logic          dn_hr;
    logic          dn_dr;
    logic          rnd_mode;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_header_i[i*HW +: HW] = s_hdr[i];
            in_data_i[i*DW +: DW]   = s_data[i];
        end
    end
    assign in_header_v_i          = s_hv;
    assign in_data_v_i            = s_dv;
    assign out_header_ready_and_i = dn_hr;
    assign out_data_ready_and_i   = dn_dr;

    // Reference model.
    int m_ptr, m_lock, m_left, m_busy;
    logic [N-1:0] a_hhs, a_dhs;
    int total, bad;
    int src_beats, exp_beats, exp_hdrs;

    task automatic check(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [HW-1:0] mk_hdr(input int b);
        logic [HW-1:0] h;
        h = {$urandom, $urandom, $urandom, $urandom};
        h[BW-1:0] = BW'(b);
        return h;
    endfunction

    task automatic check_cycle();
        int pres, idx, b, exp_src;
        logic exp_hv, exp_dv;
        logic [N-1:0] exp_hr, exp_dr;
        exp_hv = 1'b0; exp_dv = 1'b0; exp_hr = '0; exp_dr = '0;
        pres = -1; exp_src = -1; b = 0;
        a_hhs = s_hv & in_header_ready_and_o;
        a_dhs = s_dv & in_data_ready_and_o;
        if (reset_i) begin
            check("rst_hdr_v", HW'(out_header_v_o), '0);
            check("rst_data_v", HW'(out_data_v_o), '0);
            check("rst_hdr_rdy", HW'(in_header_ready_and_o), '0);
            check("rst_data_rdy", HW'(in_data_ready_and_o), '0);
            m_ptr = 0; m_lock = -1; m_left = 0; m_busy = -1;
            return;
        end
        if (m_left > 0) begin
            exp_dv = s_dv[m_busy];
            exp_dr[m_busy] = dn_dr;
        end else begin
            if (m_lock >= 0) begin
                pres = m_lock;
            end else begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (pres < 0 && s_hv[idx]) pres = idx;
                end
            end
            if (pres >= 0) begin
                exp_hv = s_hv[pres];
                exp_hr[pres] = dn_hr;
            end
        end
        check("hdr_v", HW'(out_header_v_o), HW'(exp_hv));
        check("data_v", HW'(out_data_v_o), HW'(exp_dv));
        check("hdr_rdy", HW'(in_header_ready_and_o), HW'(exp_hr));
        check("data_rdy", HW'(in_data_ready_and_o), HW'(exp_dr));
        if (exp_hv) begin
            check("hdr", out_header_o, s_hdr[pres]);
            check("src_id_h", HW'(out_src_id_o), HW'(pres));
        end
        if (exp_dv) begin
            check("data", HW'(out_data_o), HW'(s_data[m_busy]));
            check("src_id_d", HW'(out_src_id_o), HW'(m_busy));
        end
        if (exp_hv && dn_hr) begin
            b = int'(s_hdr[pres][BW-1:0]);
            m_ptr = (pres + 1) % N;
            m_lock = -1;
            exp_hdrs++;
            if (b > 0) begin
                m_busy = pres;
                m_left = b;
            end
        end else if (exp_hv && m_lock < 0) begin
            m_lock = pres;
        end
        if (exp_dv && dn_dr) begin
            m_left--;
            exp_beats++;
            if (m_left == 0) m_busy = -1;
        end
    endtask

    task automatic src_update();
        for (int s = 0; s < N; s++) begin
            if (a_hhs[s]) begin
                s_hv[s] = 1'b0;
                s_left[s] = int'(s_hdr[s][BW-1:0]);
            end
            if (a_dhs[s]) begin
                s_dv[s] = 1'b0;
                s_left[s]--;
                src_beats++;
            end
            if (!rnd_mode) begin
                if (s_left[s] > 0 && !s_dv[s]) begin
                    s_dv[s] = 1'b1;
                    s_data[s] = {$urandom, $urandom};
                end
            end else begin
                if (!s_hv[s] && s_left[s] == 0 && !s_dv[s] && $urandom_range(0, 2) == 0) begin
                    s_hv[s] = 1'b1;
                    s_hdr[s] = mk_hdr(($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 6)));
                end
                // Data may be offered before its header is accepted.
                if (!s_dv[s] && (s_left[s] > 0 || (s_hv[s] && s_hdr[s][BW-1:0] != '0))
                    && $urandom_range(0, 3) != 0) begin
                    s_dv[s] = 1'b1;
                    s_data[s] = {$urandom, $urandom};
                end
            end
        end
        if (rnd_mode) begin
            dn_hr = ($urandom_range(0, 3) != 0);
            dn_dr = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        src_update();
    endtask

    initial begin
        logic [HW-1:0] saved;
        int n;
        total = 0; bad = 0; src_beats = 0; exp_beats = 0; exp_hdrs = 0;
        m_ptr = 0; m_lock = -1; m_left = 0; m_busy = -1;
        rnd_mode = 1'b0;
        for (int i = 0; i < N; i++) begin
            s_hdr[i] = mk_hdr(0);
            s_data[i] = '0;
            s_left[i] = 0;
        end
        // Reset with sources and downstream all active: outputs must stay quiet.
        reset_i = 1'b1; s_hv = '1; s_dv = '1; dn_hr = 1'b1; dn_dr = 1'b1;
        repeat (3) tick();

        // Two header-only requests, downstream always ready.
        reset_i = 1'b0; s_dv = '0;
        tick(); check("s025_first", HW'(a_hhs), HW'(2'b01));
        tick(); check("s025_second", HW'(a_hhs), HW'(2'b10));
        tick(); check("s025_empty", HW'(a_hhs), '0);

        // Source 1 sends 4 beats; source 0 arrives mid-burst and must wait.
        s_hdr[1] = mk_hdr(4); s_hv[1] = 1'b1;
        tick(); check("s026_hdr1", HW'(a_hhs), HW'(2'b10));
        s_hdr[0] = mk_hdr(0); s_hv[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("s026_beat", HW'(a_dhs), HW'(2'b10));
            check("s026_no_hdr", HW'(a_hhs), '0);
        end
        tick(); check("s026_hdr0", HW'(a_hhs), HW'(2'b01));

        // Pointer is now 1. Source 0 stalls; source 1 arrives late.
        s_hdr[0] = mk_hdr(0); s_hv[0] = 1'b1; dn_hr = 1'b0; saved = s_hdr[0];
        tick();
        s_hdr[1] = mk_hdr(0); s_hv[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("s027_hold_hdr", out_header_o, saved);
            check("s027_hold_id", HW'(out_src_id_o), '0);
            tick();
            check("s027_no_hs", HW'(a_hhs), '0);
        end
        dn_hr = 1'b1;
        tick(); check("s027_acc0", HW'(a_hhs), HW'(2'b01));
        tick(); check("s027_acc1", HW'(a_hhs), HW'(2'b10));

        // Eight beats with downstream data ready toggling.
        s_hdr[0] = mk_hdr(8); s_hv[0] = 1'b1;
        tick(); check("s028_hdr", HW'(a_hhs), HW'(2'b01));
        n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            dn_dr = (c % 2 == 0);
            tick();
            n += int'(a_dhs[0]);
        end
        check("s028_beats", HW'(n), HW'(8));
        dn_dr = 1'b1; s_dv[0] = 1'b1;
        #1;
        check("s028_idle_rdy", HW'(in_data_ready_and_o), '0);
        check("s028_idle_v", HW'(out_data_v_o), '0);
        s_dv[0] = 1'b0;

        // Reset after 2 of 4 beats; pointer was 1 and must return to 0.
        s_hdr[0] = mk_hdr(4); s_hv[0] = 1'b1;
        tick(); check("s029_hdr", HW'(a_hhs), HW'(2'b01));
        tick(); check("s029_b0", HW'(a_dhs), HW'(2'b01));
        tick(); check("s029_b1", HW'(a_dhs), HW'(2'b01));
        reset_i = 1'b1;
        s_hdr[1] = mk_hdr(0); s_hv[1] = 1'b1;
        tick();
        reset_i = 1'b0;
        s_left[0] = 0; s_left[1] = 0;
        s_hdr[0] = mk_hdr(0); s_hv = 2'b11;
        tick(); check("s029_after_src0", HW'(a_hhs), HW'(2'b01));
        check("s029_no_data", HW'(a_dhs), '0);
        s_dv = '0;
        tick(); check("s029_after_src1", HW'(a_hhs), HW'(2'b10));

        // Randomized traffic.
        rnd_mode = 1'b1;
        repeat (3000) tick();
        check("beat_total", HW'(src_beats), HW'(exp_beats));
        check("progress", HW'(exp_hdrs > 200), HW'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
